// File: rtl/sequence_checker_if.sv
// Bundle between the game FSM / history register and the sequence checker.
// The master side drives the request and button inputs; the checker is the slave.
interface sequence_checker_if #(
    parameter int MAX_LEN = 32
);
    localparam int LEN_W = $clog2(MAX_LEN + 2);

    logic                  start;
    logic [LEN_W-1:0]      seq_len;
    logic [MAX_LEN:0][1:0] segment;
    logic [3:0]            btn;
    logic                  busy;
    logic                  pass;
    logic                  fail;
    logic [1:0]            expected_colour;
    logic [LEN_W-1:0]      remaining;

    modport master (
        output start, seq_len, segment, btn,
        input  busy, pass, fail, expected_colour, remaining
    );

    modport slave (
        input  start, seq_len, segment, btn,
        output busy, pass, fail, expected_colour, remaining
    );
endinterface

// File: rtl/sequence_checker.sv
// Walks the colour history oldest-first and compares each entry against the
// player's button presses; reports a held pass/fail verdict to the game FSM.
//
// state        | meaning
// IDLE         | out of reset, no round checked yet
// WAIT_PRESS   | awaiting the next press, timeout running
// WAIT_RELEASE | correct press seen, waiting for all buttons up
// PASS         | whole sequence matched, verdict held until next start
// FAIL         | wrong colour, multi-button press or timeout, held until start
module sequence_checker #(
    parameter int MAX_LEN        = 32,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              clk,
    input  logic              reset,
    sequence_checker_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 2);
    localparam int IDX_W = $clog2(MAX_LEN + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN + 1);
    localparam logic [TMR_W-1:0] TMR_TC  = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE,
        PASS,
        FAIL
    } state_t;

    state_t                          state, state_n;
    logic [LEN_W-1:0]                remaining, remaining_n;
    logic [TMR_W-1:0]                timer, timer_n;

    logic [SYNC_STAGES-1:0][3:0]     sync_q;
    logic [3:0]                      btn_s;
    logic [3:0]                      prev_s;
    logic                            press_event;
    logic                            press_q;
    logic [3:0]                      press_btn_q;

    logic                            start_accept;
    logic [LEN_W-1:0]                len_c;
    logic [IDX_W-1:0]                exp_idx;
    logic [1:0]                      exp_colour;
    logic                            press_onehot;
    logic [1:0]                      press_colour;

    assign btn_s       = sync_q[SYNC_STAGES-1];
    assign press_event = (prev_s == 4'b0000) && (btn_s != 4'b0000);
    assign start_accept = bus.start &&
                          (state == IDLE || state == PASS || state == FAIL);
    assign len_c = (bus.seq_len > LEN_MAX) ? LEN_MAX : bus.seq_len;

    // A press coinciding with an accepted start is dropped so that a button
    // already held when the round begins must be released before it counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q      <= '0;
            prev_s      <= '0;
            press_q     <= 1'b0;
            press_btn_q <= '0;
        end else begin
            sync_q[0] <= bus.btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_s      <= btn_s;
            press_q     <= press_event && !start_accept;
            press_btn_q <= btn_s;
        end
    end

    assign press_onehot = (press_btn_q != 4'b0000) &&
                          ((press_btn_q & (press_btn_q - 4'd1)) == 4'b0000);

    always_comb begin
        press_colour = 2'd3;
        case (press_btn_q)
            4'b0001: press_colour = 2'd0;
            4'b0010: press_colour = 2'd1;
            4'b0100: press_colour = 2'd2;
            default: press_colour = 2'd3;
        endcase
    end

    // Oldest outstanding colour sits at index remaining-1 of the live segment.
    always_comb begin
        exp_idx    = '0;
        exp_colour = 2'd0;
        if (remaining != '0) begin
            exp_idx    = IDX_W'(remaining - LEN_W'(1));
            exp_colour = bus.segment[exp_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            timer     <= '0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            timer     <= timer_n;
        end
    end

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        timer_n     = timer;

        case (state)
            IDLE, PASS, FAIL: begin
                if (bus.start) begin
                    timer_n = '0;
                    if (len_c == '0) begin
                        state_n     = PASS;
                        remaining_n = '0;
                    end else begin
                        state_n     = WAIT_PRESS;
                        remaining_n = len_c;
                    end
                end
            end

            WAIT_PRESS: begin
                if (press_q) begin
                    if (!press_onehot || press_colour != exp_colour) begin
                        state_n = FAIL;
                    end else begin
                        state_n = WAIT_RELEASE;
                        timer_n = '0;
                        if (remaining != '0) begin
                            remaining_n = remaining - LEN_W'(1);
                        end
                    end
                end else if (timer == TMR_TC) begin
                    state_n = FAIL;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end

            WAIT_RELEASE: begin
                if (btn_s == 4'b0000) begin
                    timer_n = '0;
                    if (remaining == '0) begin
                        state_n = PASS;
                    end else begin
                        state_n = WAIT_PRESS;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.busy            = (state == WAIT_PRESS) || (state == WAIT_RELEASE);
    assign bus.pass            = (state == PASS);
    assign bus.fail            = (state == FAIL);
    assign bus.remaining       = remaining;
    assign bus.expected_colour = exp_colour;
endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: pass/fail rounds, timeout, async reset,
// start handling while busy and seq_len clamping.
module tb_sequence_checker;
    localparam int MAX_LEN = 32;
    localparam int TMO     = 16;
    localparam int SYNC    = 2;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fails  = 0;

    sequence_checker_if #(.MAX_LEN(MAX_LEN)) bus ();

    sequence_checker #(
        .MAX_LEN       (MAX_LEN),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_round(input int len);
        bus.seq_len = 6'(len);
        bus.start   = 1'b1;
        tick(1);
        bus.start   = 1'b0;
    endtask

    // Press lands after SYNC stages, edge detect and the verdict register.
    task automatic press(input logic [3:0] mask);
        bus.btn = mask;
        tick(SYNC + 2);
    endtask

    task automatic release_btn();
        bus.btn = 4'b0000;
        tick(SYNC + 1);
    endtask

    initial begin
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.seq_len = '0;
        bus.btn     = 4'b0000;
        bus.segment = '0;
        bus.segment[0] = 2'd3;
        bus.segment[1] = 2'd1;
        bus.segment[2] = 2'd2;
        bus.segment[31] = 2'd1;
        bus.segment[32] = 2'd2;

        tick(3);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_pass", bus.pass, 0);
        check_eq("rst_fail", bus.fail, 0);
        check_eq("rst_rem",  bus.remaining, 0);
        check_eq("rst_exp",  bus.expected_colour, 0);
        reset = 1'b1;
        tick(2);

        // Full correct round: colours 2,1,3 oldest first
        start_round(3);
        check_eq("r1_busy", bus.busy, 1);
        check_eq("r1_rem3", bus.remaining, 3);
        check_eq("r1_exp2", bus.expected_colour, 2);
        bus.btn = 4'b0100;
        tick(SYNC + 1);
        check_eq("r1_lat_pre", bus.remaining, 3);
        tick(1);
        check_eq("r1_rem2", bus.remaining, 2);
        check_eq("r1_exp1", bus.expected_colour, 1);
        release_btn();
        press(4'b0010);
        check_eq("r1_rem1", bus.remaining, 1);
        check_eq("r1_exp3", bus.expected_colour, 3);
        release_btn();
        press(4'b1000);
        check_eq("r1_rem0", bus.remaining, 0);
        check_eq("r1_busy_rel", bus.busy, 1);
        release_btn();
        check_eq("r1_pass", bus.pass, 1);
        check_eq("r1_fail", bus.fail, 0);
        check_eq("r1_busy_end", bus.busy, 0);

        // Wrong second colour
        start_round(3);
        check_eq("r2_pass_clr", bus.pass, 0);
        check_eq("r2_rem3", bus.remaining, 3);
        press(4'b0100);
        release_btn();
        bus.btn = 4'b0001;
        tick(SYNC + 1);
        check_eq("r2_fail_pre", bus.fail, 0);
        tick(1);
        check_eq("r2_fail", bus.fail, 1);
        check_eq("r2_rem2", bus.remaining, 2);
        check_eq("r2_busy", bus.busy, 0);
        release_btn();

        // Restart from FAIL, then multi-button press
        start_round(1);
        check_eq("r3_restart_rem", bus.remaining, 1);
        check_eq("r3_fail_clr", bus.fail, 0);
        check_eq("r3_exp3", bus.expected_colour, 3);
        press(4'b0011);
        check_eq("r3_multi_fail", bus.fail, 1);
        check_eq("r3_multi_pass", bus.pass, 0);
        release_btn();

        // Zero-length round
        start_round(0);
        check_eq("r4_pass", bus.pass, 1);
        check_eq("r4_busy", bus.busy, 0);
        check_eq("r4_rem", bus.remaining, 0);

        // Long hold has no timeout; idle after release does
        start_round(2);
        check_eq("r5_exp1", bus.expected_colour, 1);
        press(4'b0010);
        check_eq("r5_rem1", bus.remaining, 1);
        tick(100);
        check_eq("r5_hold_busy", bus.busy, 1);
        check_eq("r5_hold_fail", bus.fail, 0);
        bus.btn = 4'b0000;
        tick(17);
        check_eq("r5_tmo_pre", bus.fail, 0);
        tick(2);
        check_eq("r5_tmo_fail", bus.fail, 1);
        check_eq("r5_tmo_rem", bus.remaining, 1);

        // Start while busy is ignored; async reset mid-round
        start_round(3);
        check_eq("r6_rem3", bus.remaining, 3);
        start_round(1);
        check_eq("r6_ign_rem", bus.remaining, 3);
        check_eq("r6_ign_busy", bus.busy, 1);
        press(4'b0100);
        check_eq("r6_rem2", bus.remaining, 2);
        release_btn();
        check_eq("r6_wait_busy", bus.busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("r6_arst_busy", bus.busy, 0);
        check_eq("r6_arst_rem",  bus.remaining, 0);
        check_eq("r6_arst_exp",  bus.expected_colour, 0);
        check_eq("r6_arst_fail", bus.fail, 0);
        check_eq("r6_arst_pass", bus.pass, 0);
        tick(1);
        reset = 1'b1;
        tick(2);

        // Oversized seq_len clamps to MAX_LEN+1
        start_round(40);
        check_eq("r7_rem33", bus.remaining, 33);
        check_eq("r7_exp32", bus.expected_colour, 2);
        press(4'b0100);
        check_eq("r7_rem32", bus.remaining, 32);
        check_eq("r7_exp31", bus.expected_colour, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end
endmodule
